// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: FSM states,
// parity modes and the frame-format helper functions.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    function automatic logic [3:0] data_bits_n(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction

    function automatic logic [7:0] data_mask(input logic [1:0] code);
        case (code)
            2'b00:   return 8'h1F;
            2'b01:   return 8'h3F;
            2'b10:   return 8'h7F;
            default: return 8'hFF;
        endcase
    endfunction

    // Parity over already-masked data, so unused upper bits never contribute.
    function automatic logic parity_bit(input logic [1:0] mode, input logic [7:0] masked);
        case (mode)
            PAR_EVEN: return ^masked;
            PAR_ODD:  return ~(^masked);
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO with registered occupancy count; the read word
// is only visible once the count has registered the push (no fall-through).
module uart_tx_fifo #(
    parameter int  FIFO_DEPTH = 4,
    localparam int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         wr_data_i,
    input  logic               wr_valid_i,
    output logic               wr_ready_o,
    input  logic               rd_en_i,
    output logic [7:0]         rd_data_o,
    output logic               empty_o,
    output logic [FIFO_AW:0]   count_o
);

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               push;
    logic               pop;

    assign wr_ready_o = (count_q != (FIFO_AW+1)'(FIFO_DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign push       = wr_valid_i && wr_ready_o;
    assign pop        = rd_en_i && !empty_o;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with input FIFO and per-frame format (5-8 data bits,
// none/even/odd/mark parity, 1 or 2 stops) latched when each byte is popped.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int  FIFO_DEPTH = 4,
    localparam int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [1:0]       cfg_data_bits,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_stop2,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done,
    output logic [FIFO_AW:0] fifo_count
);

    state_e     state_q;
    logic       tx_q;
    logic       done_q;
    logic [3:0] bit_cnt_q;
    logic       stop_cnt_q;
    logic [7:0] shift_q;
    logic [3:0] nbits_q;
    logic [1:0] par_mode_q;
    logic       stop2_q;
    logic       par_bit_q;

    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic [7:0] masked;
    logic       frame_end;
    logic       pop;

    uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_data_i  (s_data),
        .wr_valid_i (s_valid),
        .wr_ready_o (s_ready),
        .rd_en_i    (pop),
        .rd_data_o  (fifo_data),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    assign masked    = fifo_data & data_mask(cfg_data_bits);
    assign frame_end = (state_q == STOP) && (stop_cnt_q >= stop2_q);
    assign pop       = clk_en && !fifo_empty && ((state_q == IDLE) || frame_end);

    assign tx      = tx_q;
    assign tx_done = done_q;
    assign tx_busy = (state_q != IDLE) || !fifo_empty;

    // Frame data and its shadow format: loaded at pop, never reset.
    always_ff @(posedge clk) begin
        if (pop) begin
            shift_q    <= masked;
            nbits_q    <= data_bits_n(cfg_data_bits);
            par_mode_q <= cfg_parity;
            stop2_q    <= cfg_stop2;
            par_bit_q  <= parity_bit(cfg_parity, masked);
        end else if (clk_en && ((state_q == START) ||
                                ((state_q == DATA) && (bit_cnt_q != nbits_q)))) begin
            shift_q <= shift_q >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clk_en) begin
                case (state_q)
                    IDLE: begin
                        if (pop) begin
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            tx_q <= 1'b1;
                        end
                    end
                    START: begin
                        tx_q      <= shift_q[0];
                        bit_cnt_q <= 4'd1;
                        state_q   <= DATA;
                    end
                    DATA: begin
                        if (bit_cnt_q == nbits_q) begin
                            if (par_mode_q != PAR_NONE) begin
                                tx_q    <= par_bit_q;
                                state_q <= PARITY;
                            end else begin
                                tx_q       <= 1'b1;
                                stop_cnt_q <= 1'b0;
                                state_q    <= STOP;
                            end
                        end else begin
                            tx_q      <= shift_q[0];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                    PARITY: begin
                        tx_q       <= 1'b1;
                        stop_cnt_q <= 1'b0;
                        state_q    <= STOP;
                    end
                    STOP: begin
                        if (!frame_end) begin
                            stop_cnt_q <= 1'b1;
                            tx_q       <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                            if (pop) begin
                                tx_q    <= 1'b0;
                                state_q <= START;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= IDLE;
                            end
                        end
                    end
                    default: begin
                        tx_q    <= 1'b1;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: fixed frame vectors, randomized frames
// against a bit-list reference model, and hand-written multi-cycle sequences.
module tb_uart_tx_cfg;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [1:0] cfg_data_bits = 2'b11;
    logic [1:0] cfg_parity = 2'b00;
    logic       cfg_stop2 = 1'b0;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    logic [$clog2(DEPTH):0] fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    bit en_gen = 1'b0;
    bit en_seen = 1'b0;
    bit capturing = 1'b0;
    bit cap_bits[$];
    bit cap_done[$];
    bit exp_bits[$];
    int exp_ends[$];

    typedef struct {
        logic [7:0] data;
        logic [1:0] db;
        logic [1:0] par;
        logic       stop2;
        string      frame;
    } vec_t;
    vec_t vecs[$];

    uart_tx_cfg #(.FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .tx            (tx),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .fifo_count    (fifo_count)
    );

    initial forever #5 clk = ~clk;

    // Baud strobe: one clk-wide pulse every 4 clocks while enabled.
    initial begin
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #1;
            if (en_gen) begin
                div++;
                clk_en = (div == 4);
                if (div == 4) div = 0;
            end else begin
                div = 0;
                clk_en = 1'b0;
            end
        end
    end

    always @(posedge clk) en_seen <= clk_en;

    always @(negedge clk) begin
        if (capturing && en_seen) begin
            cap_bits.push_back(tx);
            cap_done.push_back(tx_done);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic void model_frame(input logic [7:0] d, input logic [1:0] db,
                                        input logic [1:0] par, input logic stop2);
        int n;
        bit p;
        n = 5 + int'(db);
        p = 1'b0;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_bits.push_back(d[i]);
            p ^= d[i];
        end
        if (par == 2'b01) exp_bits.push_back(p);
        if (par == 2'b10) exp_bits.push_back(!p);
        if (par == 2'b11) exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b1);
        if (stop2) exp_bits.push_back(1'b1);
        exp_ends.push_back(exp_bits.size());
    endfunction

    function automatic void load_string(input string s);
        for (int i = 0; i < s.len(); i++) exp_bits.push_back(s[i] == 8'h31);
        exp_ends.push_back(exp_bits.size());
    endfunction

    function automatic void add_vec(input logic [7:0] d, input logic [1:0] db,
                                    input logic [1:0] par, input logic stop2, input string f);
        vec_t v;
        v.data = d; v.db = db; v.par = par; v.stop2 = stop2; v.frame = f;
        vecs.push_back(v);
    endfunction

    task automatic start_capture();
        cap_bits.delete();
        cap_done.delete();
        exp_bits.delete();
        exp_ends.delete();
        capturing = 1'b1;
    endtask

    task automatic push(input logic [7:0] d);
        int t;
        t = 0;
        @(negedge clk);
        while (!s_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check("push_ready_timeout", s_ready, 1);
        s_data  = d;
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic wait_dones(input int n, input bit expect_idle, input string name);
        int seen;
        int t;
        seen = 0;
        t = 0;
        while (seen < n && t < 3000) begin
            @(negedge clk);
            t++;
            if (tx_done) begin
                seen++;
                if (seen == n && expect_idle) check({name, "_busy_at_done"}, tx_busy, 0);
            end
        end
        check({name, "_done_timeout"}, seen, n);
        repeat (12) @(negedge clk);
        capturing = 1'b0;
    endtask

    task automatic wait_en(input int n);
        int cnt;
        int t;
        cnt = 0;
        t = 0;
        while (cnt < n && t < 200) begin
            @(posedge clk);
            t++;
            if (clk_en) cnt++;
        end
        check("wait_clk_en_timeout", cnt, n);
    endtask

    task automatic analyse(input string name);
        int s;
        int len;
        int ones;
        bit ok;
        bit okd;
        string a;
        string e;
        s = -1;
        for (int i = 0; i < cap_bits.size(); i++) begin
            if (!cap_bits[i]) begin
                s = i;
                break;
            end
        end
        if (s < 0) begin
            check({name, "_no_start_bit"}, 0, 1);
            return;
        end
        len = exp_bits.size();
        ok = 1'b1;
        a = "";
        e = "";
        for (int i = 0; i < len; i++) begin
            if (s + i >= cap_bits.size()) begin
                ok = 1'b0;
                a = {a, "x"};
            end else begin
                if (cap_bits[s+i] != exp_bits[i]) ok = 1'b0;
                a = {a, cap_bits[s+i] ? "1" : "0"};
            end
            e = {e, exp_bits[i] ? "1" : "0"};
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_bits: got %s expected %s", name, a, e);
        end
        check({name, "_idle_after"}, (s + len < cap_bits.size()) ? 32'(cap_bits[s+len]) : 32'hX, 1);
        okd = 1'b1;
        foreach (exp_ends[k]) begin
            if (s + exp_ends[k] >= cap_done.size() || !cap_done[s+exp_ends[k]]) okd = 1'b0;
        end
        ones = 0;
        foreach (cap_done[k]) ones += int'(cap_done[k]);
        check({name, "_done_position"}, okd, 1);
        check({name, "_done_count"}, ones, exp_ends.size());
    endtask

    task automatic run_single(input logic [7:0] d, input logic [1:0] db, input logic [1:0] par,
                              input logic stop2, input string frame, input string name);
        cfg_data_bits = db;
        cfg_parity    = par;
        cfg_stop2     = stop2;
        start_capture();
        if (frame.len() > 0) load_string(frame);
        else model_frame(d, db, par, stop2);
        push(d);
        wait_dones(1, 1'b1, name);
        analyse(name);
    endtask

    initial begin
        logic [7:0] w [4];
        int t;
        int zeros;

        add_vec(8'hA5, 2'b11, 2'b00, 1'b0, "0101001011");
        add_vec(8'h41, 2'b10, 2'b01, 1'b1, "01000001011");
        add_vec(8'hFF, 2'b00, 2'b10, 1'b0, "01111101");
        add_vec(8'h2A, 2'b01, 2'b11, 1'b0, "001010111");
        add_vec(8'h00, 2'b11, 2'b01, 1'b1, "000000000011");
        add_vec(8'h13, 2'b00, 2'b00, 1'b0, "0110011");
        add_vec(8'h07, 2'b11, 2'b10, 1'b0, "01110000001");

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_ready", s_ready, 1);
        check("rst_count", fifo_count, 0);
        rst = 1'b0;
        en_gen = 1'b1;
        repeat (4) @(negedge clk);

        // Fixed frame vectors
        foreach (vecs[v]) begin
            run_single(vecs[v].data, vecs[v].db, vecs[v].par, vecs[v].stop2,
                       vecs[v].frame, $sformatf("vec%0d", v));
        end

        // Randomized single frames against the reference model
        for (int r = 0; r < 20; r++) begin
            run_single(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "",
                       $sformatf("rnd%0d", r));
        end

        // FIFO fill with the baud strobe stopped, then back-to-back drain
        en_gen = 1'b0;
        repeat (6) @(negedge clk);
        cfg_data_bits = 2'b10;
        cfg_parity    = 2'b01;
        cfg_stop2     = 1'b1;
        start_capture();
        for (int k = 0; k < 4; k++) begin
            w[k] = 8'($urandom_range(0, 255));
            model_frame(w[k], 2'b10, 2'b01, 1'b1);
            push(w[k]);
            @(negedge clk);
            check($sformatf("fill_count%0d", k), fifo_count, k + 1);
            check($sformatf("fill_ready%0d", k), s_ready, (k < 3) ? 1 : 0);
        end
        @(negedge clk);
        s_data  = 8'h5A;
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        @(negedge clk);
        check("full_reject_count", fifo_count, 4);
        check("full_busy", tx_busy, 1);
        check("full_tx_idle", tx, 1);
        en_gen = 1'b1;
        t = 0;
        while (fifo_count == 3'd4 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("first_pop_count", fifo_count, 3);
        check("first_pop_ready", s_ready, 1);
        wait_dones(4, 1'b1, "b2b");
        analyse("b2b");

        // Mid-frame configuration change only affects the next frame
        cfg_data_bits = 2'b11;
        cfg_parity    = 2'b00;
        cfg_stop2     = 1'b0;
        start_capture();
        w[0] = 8'($urandom_range(0, 255));
        w[1] = 8'($urandom_range(0, 255));
        model_frame(w[0], 2'b11, 2'b00, 1'b0);
        model_frame(w[1], 2'b11, 2'b10, 1'b0);
        push(w[0]);
        push(w[1]);
        t = 0;
        while (tx !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (12) @(negedge clk);
        cfg_parity = 2'b10;
        wait_dones(2, 1'b1, "cfgchg");
        analyse("cfgchg");
        cfg_parity = 2'b00;

        // Asynchronous reset in the middle of a frame with two words queued
        start_capture();
        push(8'hC3);
        push(8'h3C);
        push(8'h99);
        t = 0;
        while (tx !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("rstmid_start_seen", tx, 0);
        wait_en(3);
        @(negedge clk);
        check("rstmid_queued", fifo_count, 2);
        #2 rst = 1'b1;
        #1;
        check("rstmid_tx", tx, 1);
        check("rstmid_count", fifo_count, 0);
        check("rstmid_busy", tx_busy, 0);
        check("rstmid_ready", s_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        capturing = 1'b0;
        start_capture();
        repeat (60) @(negedge clk);
        capturing = 1'b0;
        zeros = 0;
        foreach (cap_bits[k]) zeros += int'(!cap_bits[k]);
        check("rstmid_no_restart", zeros, 0);
        check("rstmid_busy_after", tx_busy, 0);
        run_single(vecs[0].data, vecs[0].db, vecs[0].par, vecs[0].stop2, vecs[0].frame, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter with a small input FIFO and runtime frame configuration: 5–8 data bits, none/even/odd/mark parity, and 1 or 2 stop bits. It accepts bytes on a valid/ready interface and serialises them LSB-first. Bit timing comes from an external one-cycle-per-bit baud strobe (clk_en). Consecutive frames are sent back-to-back with no idle gap. It sits between the host/bus interface and the pad, alongside the baud generator.

Parameters:
FIFO_DEPTH, 4, input FIFO entries; power of 2, >= 2
FIFO_AW, $clog2(FIFO_DEPTH), FIFO pointer width; derived, not overridden

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
clk_en  in  1  baud strobe; one clk-cycle pulse per bit period
s_data  in  8  byte to send; bits above the configured width are ignored
s_valid  in  1  s_data valid
s_ready  out  1  FIFO not full; a push occurs when s_valid && s_ready
cfg_data_bits  in  2  data bits: 00=5, 01=6, 10=7, 11=8
cfg_parity  in  2  parity: 00=none, 01=even, 10=odd, 11=mark (constant 1)
cfg_stop2  in  1  0=1 stop bit, 1=2 stop bits
tx  out  1  serial line, registered, idles high
tx_busy  out  1  high when state != IDLE or the FIFO is non-empty
tx_done  out  1  one-cycle pulse on the clk_en that ends the last stop bit
fifo_count  out  FIFO_AW+1  current FIFO occupancy

Behaviour:
- Reset (async): tx=1, tx_busy=0, tx_done=0, s_ready=1, fifo_count=0, state=IDLE; FIFO pointers and all counters cleared. Reset mid-frame aborts the frame and discards FIFO contents.
- FIFO: push when s_valid && s_ready. s_ready = (count != FIFO_DEPTH), driven from the registered count. There is no fall-through: a word pushed in cycle N can be popped in cycle N+1 at the earliest. Push and pop in the same cycle leave the count unchanged. When the FIFO is full, s_ready=0, even in a cycle where a pop occurs.
- Configuration: cfg_* is sampled together with the word at pop time (frame start) and held in shadow registers. Changing cfg_* mid-frame has no effect until the next frame.
- All state transitions and tx updates happen only on cycles with clk_en=1. Each bit is therefore exactly one clk_en period.
- IDLE: tx=1. On clk_en with the FIFO non-empty: pop, load the shift register and shadow cfg, tx<=0 (start bit), go to START.
- START: on clk_en: tx<=shift[0], shift right, bit_cnt<=1, go to DATA.
- DATA: on clk_en:
  - if bit_cnt == N (N = 5..8): if parity != none, tx<=parity_bit and go to PARITY; else tx<=1, stop_cnt<=0, go to STOP.
  - otherwise: tx<=shift[0], shift, bit_cnt+1.
- Parity bit:
  - even = XOR of the N sent bits
  - odd = its inverse
  - mark = 1
  - computed on the masked data latched at pop time.
- PARITY: on clk_en: tx<=1, stop_cnt<=0, go to STOP.
- STOP: on clk_en:
  - if stop_cnt < (cfg_stop2 ? 1 : 0): stop_cnt+1, tx stays 1.
  - else: tx_done pulses. If the FIFO is non-empty, pop, tx<=0, go to START (back-to-back). Otherwise go to IDLE with tx=1.
- Frame length in clk_en periods: 1 + N + (parity?1:0) + (stop2?2:1); range 7 to 12.
- Illegal/unused state encoding: go to IDLE with tx=1.
- When clk_en is held low, the state freezes and the FIFO continues to accept data until full.

Decomposition:
- Package uart_pkg:
  - state encoding (IDLE, START, DATA, PARITY, STOP)
  - parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK)
  - data-bits code to count mapping function
- Sub-module uart_tx_fifo: synchronous FIFO, parametrised by FIFO_DEPTH and width 8, with async reset and count output. The FSM, shift register and parity logic stay in uart_tx_cfg.

Test Plan:
- 8N1, 0xA5, clk_en every 4 clk -> tx per bit period: 0,1,0,1,0,0,1,0,1,1; tx_done pulses once; tx_busy falls in the same cycle as tx_done.
- 7E2 (cfg 10/01/1), 0x41 -> tx: 0,1,0,0,0,0,0,1,0(parity),1,1; 11 periods.
- 5O1 (cfg 00/10/0), 0xFF -> data bits 1,1,1,1,1, parity 0, stop 1; bits 7:5 ignored.
- clk_en held low, push 5 words -> s_ready falls after 4th push, fifo_count=4, 5th word not accepted. Then enable clk_en -> 4 frames back-to-back with no idle period between stop and next start; s_ready rises the cycle after the first pop.
- Change cfg_parity from none to odd during the data bits of frame 1 -> frame 1 has no parity bit; frame 2 has an odd parity bit.
- Assert rst during the 3rd data bit with 2 words queued -> tx=1 immediately, fifo_count=0, tx_busy=0; after release, no frame starts until a new push.
